// File: rtl/arbitro_multiplicacion.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_multiplicacion
// Brief    : Two-port round-robin arbiter and multicycle sequencer in front of
//            a shared combinational multiplier. Latches the winner's operands,
//            holds the multiplier enabled for LATENCIA cycles, registers the
//            product and hands it back with a ready/received handshake.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_multiplicacion #(
    parameter int ANCHO    = 32,
    parameter int LATENCIA = 2      // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sol0,
    input  logic             sol1,
    input  logic [ANCHO-1:0] a0,
    input  logic [ANCHO-1:0] b0,
    input  logic [ANCHO-1:0] a1,
    input  logic [ANCHO-1:0] b1,
    output logic             acept0,
    output logic             acept1,
    output logic             listo0,
    output logic             listo1,
    input  logic             recibido0,
    input  logic             recibido1,
    output logic [ANCHO-1:0] resultado,
    output logic             ocupado,
    output logic [ANCHO-1:0] mul_a,
    output logic [ANCHO-1:0] mul_b,
    output logic             mul_en,
    input  logic [ANCHO-1:0] mul_salida
);

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        OPERA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    // Loaded on grant so the counter reaches zero on the LATENCIA-th enabled edge.
    localparam logic [3:0] CUENTA_INICIAL = 4'(LATENCIA - 1);

    estado_t    state;
    estado_t    state_next;
    logic [3:0] count;
    logic       propietario;
    logic       ultimo;
    logic       hay_solicitud;
    logic       ganador;
    logic       recibido_dueno;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        hay_solicitud  = sol0 | sol1;
        ganador        = (sol0 & sol1) ? ~ultimo : sol1;
        recibido_dueno = propietario ? recibido1 : recibido0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LIBRE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            LIBRE: begin
                if (hay_solicitud) begin
                    state_next = OPERA;
                end
            end
            OPERA: begin
                if (count == 4'd0) begin
                    state_next = ENTREGA;
                end
            end
            ENTREGA: begin
                if (recibido_dueno) begin
                    state_next = LIBRE;
                end
            end
            default: state_next = LIBRE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 4'd0;
            propietario <= 1'b0;
            ultimo      <= 1'b1;
            acept0      <= 1'b0;
            acept1      <= 1'b0;
            listo0      <= 1'b0;
            listo1      <= 1'b0;
            mul_en      <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            resultado   <= '0;
        end else begin
            acept0 <= 1'b0;
            acept1 <= 1'b0;
            case (state)
                LIBRE: begin
                    if (hay_solicitud) begin
                        mul_a       <= ganador ? a1 : a0;
                        mul_b       <= ganador ? b1 : b0;
                        propietario <= ganador;
                        acept0      <= ~ganador;
                        acept1      <= ganador;
                        count       <= CUENTA_INICIAL;
                        mul_en      <= 1'b1;
                    end
                end
                OPERA: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        resultado <= mul_salida;
                        listo0    <= ~propietario;
                        listo1    <= propietario;
                        mul_en    <= 1'b0;
                    end
                end
                ENTREGA: begin
                    if (recibido_dueno) begin
                        listo0 <= 1'b0;
                        listo1 <= 1'b0;
                        ultimo <= propietario;
                    end
                end
                default: begin
                    mul_en <= 1'b0;
                end
            endcase
        end
    end

    // Busy while an operation is in flight or awaiting pickup.
    always_comb begin
        ocupado = (state != LIBRE);
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_multiplicacion.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_multiplicacion
// Brief    : Self-checking bench for arbitro_multiplicacion. Two instances
//            (LATENCIA 2 and 1) share clock and reset; a timestamp-based
//            transaction model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_multiplicacion;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        sol0[2], sol1[2], recib0[2], recib1[2];
    logic [31:0] a0[2], b0[2], a1[2], b1[2];
    logic        acept0[2], acept1[2], listo0[2], listo1[2], mul_en[2], ocupado[2];
    logic [31:0] resultado[2], mul_a[2], mul_b[2], mul_salida[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared multiplier stand-ins, output forced to zero when not enabled.
    assign mul_salida[0] = mul_en[0] ? mul_a[0] * mul_b[0] : 32'd0;
    assign mul_salida[1] = mul_en[1] ? mul_a[1] * mul_b[1] : 32'd0;

    arbitro_multiplicacion #(.ANCHO(32), .LATENCIA(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .sol0(sol0[0]), .sol1(sol1[0]),
        .a0(a0[0]), .b0(b0[0]), .a1(a1[0]), .b1(b1[0]),
        .acept0(acept0[0]), .acept1(acept1[0]),
        .listo0(listo0[0]), .listo1(listo1[0]),
        .recibido0(recib0[0]), .recibido1(recib1[0]),
        .resultado(resultado[0]), .ocupado(ocupado[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]),
        .mul_salida(mul_salida[0])
    );

    arbitro_multiplicacion #(.ANCHO(32), .LATENCIA(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .sol0(sol0[1]), .sol1(sol1[1]),
        .a0(a0[1]), .b0(b0[1]), .a1(a1[1]), .b1(b1[1]),
        .acept0(acept0[1]), .acept1(acept1[1]),
        .listo0(listo0[1]), .listo1(listo1[1]),
        .recibido0(recib0[1]), .recibido1(recib1[1]),
        .resultado(resultado[1]), .ocupado(ocupado[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]),
        .mul_salida(mul_salida[1])
    );

    // ------------------------------------------------------------------
    // Transaction model: a grant is timestamped; the product appears LAT
    // edges later and is released on the first later edge with recibido.
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_busy[2]   = '{default: 1'b0};
    int          m_start[2]  = '{default: 0};
    bit          m_owner[2]  = '{default: 1'b0};
    bit          m_last[2]   = '{default: 1'b1};
    logic [31:0] m_a[2]      = '{default: 32'd0};
    logic [31:0] m_b[2]      = '{default: 32'd0};
    logic [31:0] m_res[2]    = '{default: 32'd0};
    bit          e_acept0[2] = '{default: 1'b0};
    bit          e_acept1[2] = '{default: 1'b0};
    bit          e_listo0[2] = '{default: 1'b0};
    bit          e_listo1[2] = '{default: 1'b0};
    bit          e_mul_en[2] = '{default: 1'b0};
    bit          m_w;

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_owner[i] = 1'b0; m_last[i] = 1'b1;
                m_a[i] = 32'd0; m_b[i] = 32'd0; m_res[i] = 32'd0;
                e_acept0[i] = 1'b0; e_acept1[i] = 1'b0;
                e_listo0[i] = 1'b0; e_listo1[i] = 1'b0; e_mul_en[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                e_acept0[i] = 1'b0;
                e_acept1[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (sol0[i] || sol1[i]) begin
                        m_w = (sol0[i] && sol1[i]) ? !m_last[i] : sol1[i];
                        m_owner[i] = m_w;
                        m_a[i] = m_w ? a1[i] : a0[i];
                        m_b[i] = m_w ? b1[i] : b0[i];
                        if (m_w) e_acept1[i] = 1'b1; else e_acept0[i] = 1'b1;
                        m_start[i] = cyc;
                        m_busy[i] = 1'b1;
                    end
                end else if (cyc - m_start[i] == lat(i)) begin
                    m_res[i] = m_a[i] * m_b[i];
                    if (m_owner[i]) e_listo1[i] = 1'b1; else e_listo0[i] = 1'b1;
                end else if (cyc - m_start[i] > lat(i) &&
                             (m_owner[i] ? recib1[i] : recib0[i])) begin
                    e_listo0[i] = 1'b0;
                    e_listo1[i] = 1'b0;
                    m_last[i] = m_owner[i];
                    m_busy[i] = 1'b0;
                end
                e_mul_en[i] = m_busy[i] && (cyc - m_start[i] < lat(i));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ctl%0d{acept0,acept1,listo0,listo1,mul_en,ocupado}", i),
                  32'({acept0[i], acept1[i], listo0[i], listo1[i], mul_en[i], ocupado[i]}),
                  32'({e_acept0[i], e_acept1[i], e_listo0[i], e_listo1[i], e_mul_en[i], m_busy[i]}));
            check($sformatf("resultado%0d", i), resultado[i], m_res[i]);
            check($sformatf("mul_a%0d", i), mul_a[i], m_a[i]);
            check($sformatf("mul_b%0d", i), mul_b[i], m_b[i]);
            check($sformatf("acept_exclusive%0d", i), 32'(acept0[i] & acept1[i]), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int order[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            sol0[i] = 1'b0; sol1[i] = 1'b0; recib0[i] = 1'b0; recib1[i] = 1'b0;
            a0[i] = 32'd0; b0[i] = 32'd0; a1[i] = 32'd0; b1[i] = 32'd0;
        end
        repeat (2) step();
        check("reset_ocupado", 32'(ocupado[0]), 32'd0);
        check("reset_resultado", resultado[0], 32'd0);
        check("reset_mul_en", 32'(mul_en[0]), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request, recibido0 tied high.
        sol0[0] = 1'b1; a0[0] = 32'd8; b0[0] = 32'd16; recib0[0] = 1'b1;
        step();
        sol0[0] = 1'b0;
        check("t1_acept0", 32'(acept0[0]), 32'd1);
        check("t1_mul_a", mul_a[0], 32'd8);
        check("t1_mul_en_e0", 32'(mul_en[0]), 32'd1);
        step();
        check("t1_acept0_pulse", 32'(acept0[0]), 32'd0);
        check("t1_mul_en_e1", 32'(mul_en[0]), 32'd1);
        step();
        check("t1_listo0", 32'(listo0[0]), 32'd1);
        check("t1_resultado", resultado[0], 32'd128);
        check("t1_mul_en_e2", 32'(mul_en[0]), 32'd0);
        step();
        check("t1_listo0_clear", 32'(listo0[0]), 32'd0);
        check("t1_libre", 32'(ocupado[0]), 32'd0);
        recib0[0] = 1'b0;

        // Simultaneous requests after reset: 0 first, then 1.
        pulse_reset();
        sol0[0] = 1'b1; sol1[0] = 1'b1;
        a0[0] = 32'd20; b0[0] = 32'd100; a1[0] = 32'd34; b1[0] = 32'd122;
        recib0[0] = 1'b1; recib1[0] = 1'b1;
        step();
        check("t2_acept0", 32'(acept0[0]), 32'd1);
        check("t2_acept1_low", 32'(acept1[0]), 32'd0);
        sol0[0] = 1'b0;
        step();
        step();
        check("t2_res0", resultado[0], 32'd2000);
        check("t2_listo0", 32'(listo0[0]), 32'd1);
        step();
        step();
        check("t2_acept1", 32'(acept1[0]), 32'd1);
        sol1[0] = 1'b0;
        step();
        step();
        check("t2_res1", resultado[0], 32'd4148);
        check("t2_listo1", 32'(listo1[0]), 32'd1);
        check("t2_listo0_low", 32'(listo0[0]), 32'd0);
        step();

        // Both held across four transactions: alternate 0,1,0,1.
        sol0[0] = 1'b1; sol1[0] = 1'b1;
        a0[0] = 32'd3; b0[0] = 32'd5; a1[0] = 32'd7; b1[0] = 32'd11;
        for (int k = 0; k < 16; k++) begin
            step();
            if (acept0[0]) order.push_back(0);
            if (acept1[0]) order.push_back(1);
        end
        sol0[0] = 1'b0; sol1[0] = 1'b0;
        check("t3_grant_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            check($sformatf("t3_grant%0d", k), 32'(order[k]), 32'(k % 2));
        repeat (2) step();

        // Owner withholds recibido0 while requester 1 waits.
        sol0[0] = 1'b1; a0[0] = 32'd8; b0[0] = 32'd16; recib0[0] = 1'b0; recib1[0] = 1'b1;
        step();
        check("t4_acept0", 32'(acept0[0]), 32'd1);
        sol0[0] = 1'b0; sol1[0] = 1'b1; a1[0] = 32'd34; b1[0] = 32'd122;
        repeat (2) step();
        check("t4_listo0", 32'(listo0[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_listo0", 32'(listo0[0]), 32'd1);
            check("t4_hold_res", resultado[0], 32'd128);
            check("t4_no_acept1", 32'(acept1[0]), 32'd0);
        end
        recib0[0] = 1'b1;
        step();
        check("t4_release", 32'(listo0[0]), 32'd0);
        check("t4_no_acept1_yet", 32'(acept1[0]), 32'd0);
        recib0[0] = 1'b0;
        step();
        check("t4_acept1", 32'(acept1[0]), 32'd1);
        sol1[0] = 1'b0;
        repeat (4) step();

        // Reset mid-OPERA aborts; next tie goes to requester 0.
        sol0[0] = 1'b1; a0[0] = 32'd5; b0[0] = 32'd9; recib0[0] = 1'b1;
        step();
        sol0[0] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_mul_en", 32'(mul_en[0]), 32'd0);
        check("t5_async_ocupado", 32'(ocupado[0]), 32'd0);
        check("t5_async_resultado", resultado[0], 32'd0);
        check("t5_async_mul_a", mul_a[0], 32'd0);
        check("t5_async_listo", 32'({listo0[0], listo1[0]}), 32'd0);
        step();
        rst_n = 1'b1;
        sol0[0] = 1'b1; sol1[0] = 1'b1; a1[0] = 32'd2; b1[0] = 32'd3; recib1[0] = 1'b1;
        step();
        check("t5_tie_acept0", 32'(acept0[0]), 32'd1);
        check("t5_tie_acept1", 32'(acept1[0]), 32'd0);
        sol0[0] = 1'b0; sol1[0] = 1'b0;
        repeat (4) step();

        // LATENCIA=1 instance, stray recibido1 during ENTREGA.
        sol0[1] = 1'b1; a0[1] = 32'd34; b0[1] = 32'd122; recib0[1] = 1'b0; recib1[1] = 1'b1;
        step();
        check("t6_acept0", 32'(acept0[1]), 32'd1);
        check("t6_mul_en_e0", 32'(mul_en[1]), 32'd1);
        sol0[1] = 1'b0;
        step();
        check("t6_listo0", 32'(listo0[1]), 32'd1);
        check("t6_res", resultado[1], 32'd4148);
        check("t6_mul_en_e1", 32'(mul_en[1]), 32'd0);
        step();
        check("t6_stray_listo0", 32'(listo0[1]), 32'd1);
        check("t6_stray_ocupado", 32'(ocupado[1]), 32'd1);
        recib0[1] = 1'b1;
        step();
        check("t6_release", 32'(listo0[1]), 32'd0);
        check("t6_libre", 32'(ocupado[1]), 32'd0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_multiplicacion.md
Name: arbitro_multiplicacion

Overview:
- Sequencer and two-port round-robin arbiter in front of the shared combinational `multiplicacion` unit (operands `a`, `b`, `enable`, output `salida`).
- Owns the multiplier's operand and enable inputs. Holds them stable for a programmable number of cycles (multicycle path), then registers the product.
- Returns the registered product to the requester that won the grant, using a request/accept and ready/received handshake.

Parameters:
- ANCHO, 32, operand and result width in bits; matches the multiplier.
- LATENCIA, 2, cycles `mul_en` stays high before `mul_salida` is captured; legal range 1 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sol0, sol1  in  1 each  request from requester 0 / 1.
- a0, b0, a1, b1  in  ANCHO each  operands of requester 0 / 1; stable while the matching sol is high.
- acept0, acept1  out  1 each  one-cycle pulse: request granted, operands latched.
- listo0, listo1  out  1 each  resultado is valid for requester 0 / 1; held until received.
- recibido0, recibido1  in  1 each  requester has consumed resultado.
- resultado  out  ANCHO  registered product.
- ocupado  out  1  high in states OPERA and ENTREGA.
- mul_a, mul_b  out  ANCHO each  drive multiplier `a` / `b`.
- mul_en  out  1  drives multiplier `enable`.
- mul_salida  in  ANCHO  multiplier `salida`.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state = LIBRE; ultimo = 1, so requester 0 wins the first tie.
  - count = 0; propietario = 0.
  - acept0, acept1, listo0, listo1, mul_en, ocupado = 0.
  - resultado, mul_a, mul_b = 0.
- Registered signals: every output except ocupado. ocupado is decoded from state.
- State LIBRE:
  - mul_en = 0; mul_a and mul_b hold their last values.
  - sol0 and sol1 are sampled only in this state.
  - Winner selection at the rising edge:
    - Only one sol high: that requester wins.
    - Both sol high: the requester other than ultimo wins.
  - On that edge:
    - Latch the winner's a/b into mul_a/mul_b.
    - Set propietario = winner.
    - Assert the winner's acept for exactly the next cycle.
    - Set count = LATENCIA-1, mul_en = 1, next state = OPERA.
  - No sol high: remain in LIBRE.
- State OPERA:
  - mul_en = 1; operands are frozen.
  - If count != 0: decrement count each edge.
  - When count == 0, at that edge:
    - resultado <= mul_salida.
    - Set the owner's listo to 1.
    - mul_en <= 0; next state = ENTREGA.
  - mul_en is therefore high for exactly LATENCIA cycles.
  - Latency: the LIBRE sampling edge is edge 0; listo rises on edge LATENCIA.
- State ENTREGA:
  - resultado and the owner's listo are held.
  - When the owner's recibido is high at an edge:
    - Clear listo; set ultimo = propietario; next state = LIBRE.
  - recibido from the non-owner is ignored.
- Arithmetic: resultado is the low ANCHO bits as supplied by the multiplier. No overflow flag is produced.
- Boundary conditions:
  - A sol raised while ocupado = 1 waits; it is served on the first LIBRE edge.
  - A sol dropped before acept is never served.
  - Holding sol high after acept creates a new request, evaluated on the next LIBRE edge.
  - After an ENTREGA→LIBRE edge, LIBRE lasts at least one cycle. Minimum request-to-request throughput is LATENCIA+2 cycles.
  - recibido asserted outside ENTREGA has no effect.
  - Reset in OPERA or ENTREGA aborts the operation: the result is discarded, listo drops immediately, and no acept is re-issued.
  - Back-to-back requests: with both sol held continuously, grants alternate 0,1,0,1.

Test Plan:
- LATENCIA=2; sol0=1, a0=8, b0=16; recibido0 tied high.
  -> acept0 pulses one cycle; mul_en high 2 cycles; listo0=1 with resultado=128 on edge 2; returns to LIBRE the next edge.
- sol0 and sol1 asserted in the same cycle; a0=20, b0=100; a1=34, b1=122.
  -> first grant goes to requester 0, resultado=2000.
  -> second grant goes to requester 1, resultado=4148, listo1 only.
- Hold both sol high across 4 transactions.
  -> grant order 0,1,0,1; acept never asserted for both in the same cycle.
- Owner withholds recibido0 for 5 cycles while sol1 is high.
  -> listo0 and resultado=128 stay stable; acept1 appears only after recibido0 is accepted plus one LIBRE cycle.
- Drop rst_n mid-OPERA, then release.
  -> all outputs 0 asynchronously; state LIBRE; first tie after release goes to requester 0.
- LATENCIA=1 build with a0=34, b0=122.
  -> mul_en high exactly 1 cycle; listo0 on edge 1; resultado=4148; stray recibido1 during ENTREGA ignored.
